vec_exe_unit: RTL and testbench



---
 rtl/vec_exe_unit.sv | 202 ++++++++++++++++++++
 tb/tb_vec_exe_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_exe_unit.sv
// vec_exe_unit: strip-mining vector execute stage.
// Accepts one command, consumes ceil(vlen/LANES) operand beats and emits one
// registered result beat per operand beat (mask, write address, ovf/zero flags).
// Handshake rule on every interface: a transfer happens on the rising edge where
// valid && ready are both 1; valid never waits on ready, and ready may depend on
// valid only through the registered output state.
// Build option: define VEXE_SAT_EN to make ADD/SUB saturate instead of wrap.
module vec_exe_unit #(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int VLW   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [4:0]            in_shamt,
  input  logic                  in_scalar_en,
  input  logic [DW-1:0]         in_scalar,
  input  logic [AW-1:0]         in_rd_base,
  input  logic [VLW-1:0]        in_vlen,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [LANES*DW-1:0]   src_a,
  input  logic [LANES*DW-1:0]   src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      out_mask,
  output logic [AW-1:0]         out_waddr,
  output logic                  out_ovf,
  output logic                  out_zero,
  output logic                  out_last,
  output logic                  cmd_done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;

  localparam int SW = $clog2(DW);
  localparam int XW = VLW + $clog2(LANES) + 2;

  logic [0:0]            state_q, state_d;
  logic [2:0]            op_q;
  logic [SW-1:0]         shamt_q;
  logic                  scalar_en_q;
  logic [DW-1:0]         scalar_q;
  logic [AW-1:0]         rd_base_q;
  logic [VLW-1:0]        vlen_q;
  logic [VLW-1:0]        total_q;
  logic [VLW-1:0]        issued_q;

  logic                  out_valid_q;
  logic [LANES*DW-1:0]   out_data_q;
  logic [LANES-1:0]      out_mask_q;
  logic [AW-1:0]         out_waddr_q;
  logic                  out_ovf_q;
  logic                  out_zero_q;
  logic                  out_last_q;
  logic                  done_q;

  logic                  cmd_fire, src_fire, out_fire;
  logic [XW-1:0]         beat_base;
  logic [LANES*DW-1:0]   lane_res;
  logic [LANES-1:0]      lane_mask;
  logic [LANES-1:0]      lane_ovf;
  logic [DW-1:0]         b_sel;
  logic [DW:0]           alu;

  // One lane: returns {signed_overflow, result}. Overflow is only meaningful for ADD/SUB.
  function automatic logic [DW:0] lane_alu(input logic [2:0] op, input logic [SW-1:0] sh,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          ovf;
    r   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        r   = a + b;
        ovf = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        r   = a - b;
        ovf = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  r = a << sh;
      default: r = $signed(a) >>> sh;
    endcase
`ifdef VEXE_SAT_EN
    // Overflow direction follows the sign of operand A for both ADD and SUB.
    if (ovf) r = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return {ovf, r};
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign src_ready = (state_q == S_RUN) && (issued_q < total_q) && (!out_valid_q || out_ready);
  assign cmd_fire  = in_valid && in_ready;
  assign src_fire  = src_valid && src_ready;
  assign out_fire  = out_valid_q && out_ready;

  // Lane datapath for the beat currently offered on src_*; masked lanes forced to zero.
  always_comb begin
    lane_res  = '0;
    lane_mask = '0;
    lane_ovf  = '0;
    b_sel     = '0;
    alu       = '0;
    beat_base = XW'(issued_q) * XW'(LANES);
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = (beat_base + XW'(i)) < XW'(vlen_q);
      b_sel        = scalar_en_q ? scalar_q : src_b[i*DW +: DW];
      alu          = lane_alu(op_q, shamt_q, src_a[i*DW +: DW], b_sel);
      if (lane_mask[i]) begin
        lane_res[i*DW +: DW] = alu[DW-1:0];
        lane_ovf[i]          = alu[DW];
      end
    end
  end

  // FSM: zero-length commands never leave IDLE; RUN ends when the last beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire && (in_vlen != '0)) state_d = S_RUN;
      default: if (out_fire && out_last_q)      state_d = S_IDLE;
    endcase
  end

  // Command latch, beat counter, result register and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      shamt_q     <= '0;
      scalar_en_q <= 1'b0;
      scalar_q    <= '0;
      rd_base_q   <= '0;
      vlen_q      <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_waddr_q <= '0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (cmd_fire && (in_vlen == '0)) || (out_fire && out_last_q);
      if (cmd_fire) begin
        op_q        <= in_op;
        shamt_q     <= in_shamt[SW-1:0];
        scalar_en_q <= in_scalar_en;
        scalar_q    <= in_scalar;
        rd_base_q   <= in_rd_base;
        vlen_q      <= in_vlen;
        total_q     <= VLW'((XW'(in_vlen) + XW'(LANES - 1)) / XW'(LANES));
        issued_q    <= '0;
      end
      // A new beat may replace the one leaving in the same cycle, so no bubble.
      if (src_fire) begin
        issued_q    <= issued_q + 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= lane_res;
        out_mask_q  <= lane_mask;
        out_waddr_q <= rd_base_q + AW'(issued_q);
        out_ovf_q   <= (op_q == OP_ADD || op_q == OP_SUB) && (|lane_ovf);
        out_zero_q  <= (lane_res == '0);
        out_last_q  <= (issued_q == total_q - 1'b1);
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_waddr = out_waddr_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;
  assign out_last  = out_last_q;
  assign cmd_done  = done_q;

endmodule

// File: tb/tb_vec_exe_unit.sv
// Self-checking bench for vec_exe_unit (LANES=8, DW=32, AW=5, VLW=8).
// Expected beats come from a lane-by-lane arithmetic model; follows VEXE_SAT_EN.
module tb_vec_exe_unit;
  localparam int LANES = 8;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int VLW   = 8;
  localparam int BW    = LANES * DW;
  localparam int EW    = BW + LANES + AW + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = '0;
  logic [4:0]      in_shamt = '0;
  logic            in_scalar_en = 1'b0;
  logic [DW-1:0]   in_scalar = '0;
  logic [AW-1:0]   in_rd_base = '0;
  logic [VLW-1:0]  in_vlen = '0;
  logic            src_valid = 1'b0;
  logic            src_ready;
  logic [BW-1:0]   src_a = '0;
  logic [BW-1:0]   src_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [BW-1:0]   out_data;
  logic [LANES-1:0] out_mask;
  logic [AW-1:0]   out_waddr;
  logic            out_ovf, out_zero, out_last, cmd_done;

  vec_exe_unit #(.LANES(LANES), .DW(DW), .AW(AW), .VLW(VLW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_shamt(in_shamt),
    .in_scalar_en(in_scalar_en), .in_scalar(in_scalar), .in_rd_base(in_rd_base), .in_vlen(in_vlen),
    .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .out_waddr(out_waddr), .out_ovf(out_ovf), .out_zero(out_zero), .out_last(out_last),
    .cmd_done(cmd_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  logic [BW-1:0] a_q[$];
  logic [BW-1:0] b_q[$];
  bit            busy = 0;
  bit            done_next = 0;
  bit            stalled = 0;
  logic [EW-1:0] hold_beat = '0;
  bit            rdy_auto = 1;

  function logic [EW-1:0] pack_out();
    return {out_data, out_mask, out_waddr, out_ovf, out_zero, out_last};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_beat(input logic [2:0] op, input logic [4:0] shamt,
      input bit sen, input logic [31:0] scalar, input logic [AW-1:0] rd, input int vlen,
      input int k, input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0]    d;
    logic [LANES-1:0] m;
    logic [AW-1:0]    wa;
    logic [31:0]      res;
    bit               ovf, zero;
    longint           sa, sb, r;
    int               total;
    d = '0; m = '0; ovf = 0; zero = 1;
    total = (vlen + LANES - 1) / LANES;
    for (int i = 0; i < LANES; i++) begin
      sa = $signed(a[i*DW +: DW]);
      sb = sen ? $signed(scalar) : $signed(b[i*DW +: DW]);
      case (op)
        3'd0: r = sa + sb;
        3'd1: r = sa - sb;
        3'd2: r = sa & sb;
        3'd3: r = sa | sb;
        3'd4: r = sa ^ sb;
        3'd5: r = (sa < sb) ? 64'sd1 : 64'sd0;
        3'd6: r = sa << shamt;
        default: r = sa >>> shamt;
      endcase
      m[i] = (k * LANES + i) < vlen;
      if (m[i]) begin
        if (op <= 3'd1 && (r > 64'sh7FFFFFFF || r < -64'sh80000000)) begin
          ovf = 1;
`ifdef VEXE_SAT_EN
          r = (r > 0) ? 64'sh7FFFFFFF : -64'sh80000000;
`endif
        end
        res = r[31:0];
        d[i*DW +: DW] = res;
        if (res != 0) zero = 0;
      end
    end
    wa = AW'(int'(rd) + k);
    return {d, m, wa, ovf, zero, (k == total - 1)};
  endfunction

  function automatic logic [BW-1:0] rand_vec();
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0: v[i*DW +: DW] = 32'h7FFFFFFF;
        1: v[i*DW +: DW] = 32'h80000000;
        2: v[i*DW +: DW] = 32'h0;
        3: v[i*DW +: DW] = $urandom_range(0, 7);
        default: v[i*DW +: DW] = $urandom();
      endcase
    end
    return v;
  endfunction

  function automatic logic [BW-1:0] fill(input logic [31:0] val);
    logic [BW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = val;
    return v;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy = 0; done_next = 0; stalled = 0;
    end else begin
      check("cmd_done", cmd_done, done_next);
      check("in_ready", in_ready, !busy);
      done_next = 0;
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_beat", pack_out(), hold_beat);
      end
      if (out_valid && !out_ready) check("src_ready_stall", src_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", pack_out(), '0 - 1);
        else check("beat", pack_out(), exp_q.pop_front());
        got_q.push_back(pack_out());
        if (out_last) begin busy = 0; done_next = 1; end
      end
      stalled   = out_valid && !out_ready;
      hold_beat = pack_out();
      if (in_valid && in_ready) begin
        if (in_vlen == 0) done_next = 1;
        else busy = 1;
      end
    end
  end

  // Random back-pressure when not under directed control.
  initial forever begin
    @(posedge clk); #1;
    if (rdy_auto) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_fire(input int which);
    bit f;
    f = 0;
    for (int c = 0; c < 200 && !f; c++) begin
      @(negedge clk);
      f = (which == 0) ? in_ready : src_ready;
      @(posedge clk); #1;
    end
    check(which == 0 ? "in_handshake_timeout" : "src_handshake_timeout", f, 1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [4:0] shamt, input bit sen,
                         input logic [31:0] scalar, input logic [AW-1:0] rd, input int vlen);
    int  total;
    bit  seen;
    total = (vlen + LANES - 1) / LANES;
    while (a_q.size() < total) a_q.push_back(rand_vec());
    while (b_q.size() < total) b_q.push_back(rand_vec());
    for (int k = 0; k < total; k++)
      exp_q.push_back(model_beat(op, shamt, sen, scalar, rd, vlen, k, a_q[k], b_q[k]));
    @(posedge clk); #1;
    in_op = op; in_shamt = shamt; in_scalar_en = sen; in_scalar = scalar;
    in_rd_base = rd; in_vlen = VLW'(vlen); in_valid = 1;
    wait_fire(0);
    in_valid = 0;
    for (int k = 0; k < total; k++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      src_a = a_q[k]; src_b = b_q[k]; src_valid = 1;
      wait_fire(1);
      src_valid = 0;
    end
    a_q.delete(); b_q.delete();
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      seen = cmd_done;
    end
    check("cmd_done_timeout", seen, 1);
    check("drained", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] lane_of(input logic [EW-1:0] g, input int i);
    logic [BW-1:0] d;
    d = g[EW-1 -: BW];
    return d[i*DW +: DW];
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [EW-1:0] g;
    logic [BW-1:0] v;
    bit            seen;

    // Reset values
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_src_ready", src_ready, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_outputs", pack_out(), '0);
    @(posedge clk); #1;
    rst = 0;

    // ADD with scalar 100, lanes = i
    got_q.delete();
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = i;
    a_q.push_back(v);
    run_cmd(3'd0, 5'd0, 1, 32'd100, 5'd2, 8);
    check("t1_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q[0];
      for (int i = 0; i < LANES; i++) check("t1_lane", lane_of(g, i), 100 + i);
      check("t1_mask", g[AW+3 +: LANES], 8'hFF);
      check("t1_waddr", g[3 +: AW], 5'd2);
      check("t1_ovf", g[2], 0);
      check("t1_last", g[0], 1);
    end

    // SUB 50-8 over 11 elements
    got_q.delete();
    a_q.push_back(fill(50)); a_q.push_back(fill(50));
    b_q.push_back(fill(8));  b_q.push_back(fill(8));
    run_cmd(3'd1, 5'd0, 0, 32'd0, 5'd4, 11);
    check("t2_count", got_q.size(), 2);
    if (got_q.size() > 1) begin
      check("t2_b0_mask", got_q[0][AW+3 +: LANES], 8'hFF);
      check("t2_b0_waddr", got_q[0][3 +: AW], 5'd4);
      check("t2_b0_lane7", lane_of(got_q[0], 7), 42);
      check("t2_b1_mask", got_q[1][AW+3 +: LANES], 8'h07);
      check("t2_b1_waddr", got_q[1][3 +: AW], 5'd5);
      check("t2_b1_lane2", lane_of(got_q[1], 2), 42);
      check("t2_b1_lane3", lane_of(got_q[1], 3), 0);
      check("t2_b1_last", got_q[1][0], 1);
    end

    // Signed overflow on ADD, none on AND
    got_q.delete();
    a_q.push_back(BW'(32'h7FFFFFFF)); b_q.push_back(BW'(32'h1));
    run_cmd(3'd0, 5'd0, 0, 32'd0, 5'd0, 1);
    if (got_q.size() > 0) begin
      check("t3_ovf", got_q[0][2], 1);
`ifdef VEXE_SAT_EN
      check("t3_lane0", lane_of(got_q[0], 0), 32'h7FFFFFFF);
`else
      check("t3_lane0", lane_of(got_q[0], 0), 32'h80000000);
`endif
    end else check("t3_count", got_q.size(), 1);
    got_q.delete();
    a_q.push_back(BW'(32'h7FFFFFFF)); b_q.push_back(BW'(32'h1));
    run_cmd(3'd2, 5'd0, 0, 32'd0, 5'd0, 1);
    if (got_q.size() > 0) begin
      check("t3_and_ovf", got_q[0][2], 0);
      check("t3_and_lane0", lane_of(got_q[0], 0), 32'h1);
    end else check("t3_and_count", got_q.size(), 1);

    // Back-pressure: out_ready low for 3 cycles after the first beat
    got_q.delete();
    rdy_auto = 0;
    out_ready = 0;
    fork
      run_cmd(3'd4, 5'd0, 0, 32'd0, 5'd9, 24);
      begin
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
          @(negedge clk);
          seen = out_valid;
        end
        check("t4_first_beat", seen, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    check("t4_count", got_q.size(), 3);
    for (int k = 0; k < 3 && k < got_q.size(); k++)
      check("t4_waddr", got_q[k][3 +: AW], AW'(9 + k));
    rdy_auto = 1;

    // Write-address wrap
    got_q.delete();
    run_cmd(3'd0, 5'd0, 0, 32'd0, 5'd31, 16);
    if (got_q.size() == 2) begin
      check("t5_waddr0", got_q[0][3 +: AW], 5'd31);
      check("t5_waddr1", got_q[1][3 +: AW], 5'd0);
    end else check("t5_count", got_q.size(), 2);

    // Zero-length command
    got_q.delete();
    @(posedge clk); #1;
    in_op = 3'd0; in_vlen = '0; in_valid = 1;
    @(negedge clk);
    check("t6_in_ready_T", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("t6_cmd_done", cmd_done, 1);
    check("t6_in_ready", in_ready, 1);
    check("t6_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    check("t6_no_beats", got_q.size(), 0);

    // Reset in the middle of a 3-beat command
    rdy_auto = 0;
    @(posedge clk); #1;
    out_ready = 0;
    in_op = 3'd0; in_vlen = 8'd24; in_rd_base = 5'd0; in_scalar_en = 0; in_valid = 1;
    wait_fire(0);
    in_valid = 0;
    src_a = rand_vec(); src_b = rand_vec(); src_valid = 1;
    wait_fire(1);
    src_valid = 0;
    @(negedge clk);
    check("t7_first_beat", out_valid, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_out_valid", out_valid, 0);
    check("t7_in_ready", in_ready, 1);
    check("t7_src_ready", src_ready, 0);
    check("t7_cmd_done", cmd_done, 0);
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    rdy_auto = 1;
    got_q.delete();
    run_cmd(3'd0, 5'd0, 0, 32'd0, 5'd3, 8);
    check("t7_fresh_count", got_q.size(), 1);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      int vl;
      vl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(1, 64);
      run_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
              $urandom(), 5'($urandom_range(0, 31)), vl);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
